// File: rtl/pc_pkg.sv
// Shared constants, types and operation names for the program counter datapath.
package pc_pkg;

    localparam int PC_WIDTH        = 16;
    localparam int PC_OFFSET_WIDTH = 9;
    localparam int PC_RESET_VALUE  = 0;

    typedef logic signed [PC_WIDTH-1:0]        pc_t;
    typedef logic signed [PC_OFFSET_WIDTH-1:0] pc_offset_t;

    typedef enum logic [1:0] {
        PC_RESET,
        PC_LOAD,
        PC_OFFSET,
        PC_INC
    } pc_op_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-value selection for the program counter: priority encode
// of reset/load/offset/increment plus the sign-extending adder and wrap detect.
module pc_next_logic
    import pc_pkg::*;
#(
    parameter int                WIDTH        = PC_WIDTH,
    parameter int                OFFSET_WIDTH = PC_OFFSET_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = WIDTH'(PC_RESET_VALUE)
) (
    input  logic signed [WIDTH-1:0]        current,
    input  logic                           reset,
    input  logic                           load_enable,
    input  logic signed [WIDTH-1:0]        load_value,
    input  logic                           offset_enable,
    input  logic signed [OFFSET_WIDTH-1:0] offset,
    output logic signed [WIDTH-1:0]        next_value,
    output pc_op_e                         op,
    output logic                           wrap
);

    logic signed [WIDTH-1:0] offset_ext;
    logic [WIDTH:0]          inc_sum;
    logic [WIDTH:0]          off_sum;

    assign offset_ext = WIDTH'(offset);
    assign inc_sum    = {1'b0, current} + {{WIDTH{1'b0}}, 1'b1};
    assign off_sum    = {1'b0, current} + {1'b0, offset_ext};

    always_comb begin
        op         = PC_INC;
        next_value = inc_sum[WIDTH-1:0];
        wrap       = inc_sum[WIDTH];
        if (reset) begin
            op         = PC_RESET;
            next_value = RESET_VALUE;
            wrap       = 1'b0;
        end else if (load_enable) begin
            op         = PC_LOAD;
            next_value = load_value;
            wrap       = 1'b0;
        end else if (offset_enable) begin
            op         = PC_OFFSET;
            next_value = off_sum[WIDTH-1:0];
            // A negative offset is an unsigned add of its two's complement:
            // a missing carry out is exactly a borrow below zero.
            wrap       = off_sum[WIDTH] ^ offset[OFFSET_WIDTH-1];
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter register with jump, signed relative branch and increment.
// Define PC_WRAP_FLAG_EN to add the registered Wrapped carry/borrow flag.
module program_counter
    import pc_pkg::*;
#(
    parameter int                WIDTH        = PC_WIDTH,
    parameter int                OFFSET_WIDTH = PC_OFFSET_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = WIDTH'(PC_RESET_VALUE)
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic signed [WIDTH-1:0]        LoadValue,
    input  logic                           LoadEnable,
    input  logic signed [OFFSET_WIDTH-1:0] Offset,
    input  logic                           OffsetEnable,
`ifdef PC_WRAP_FLAG_EN
    output logic                           Wrapped,
`endif
    output logic signed [WIDTH-1:0]        CounterValue
);

    logic signed [WIDTH-1:0] next_value;
    pc_op_e                  op;
    logic                    wrap;

    pc_next_logic #(
        .WIDTH        (WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .RESET_VALUE  (RESET_VALUE)
    ) u_next (
        .current       (CounterValue),
        .reset         (Reset),
        .load_enable   (LoadEnable),
        .load_value    (LoadValue),
        .offset_enable (OffsetEnable),
        .offset        (Offset),
        .next_value    (next_value),
        .op            (op),
        .wrap          (wrap)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            CounterValue <= RESET_VALUE;
        end else begin
            CounterValue <= next_value;
        end
    end

`ifdef PC_WRAP_FLAG_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Wrapped <= 1'b0;
        end else begin
            Wrapped <= wrap && ((op == PC_INC) || (op == PC_OFFSET));
        end
    end
`else
    logic unused_next_info;
    assign unused_next_info = wrap ^ (op == PC_INC);
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed literal cases plus a
// randomized run compared every cycle against an integer-arithmetic model.
module tb_program_counter;

    logic               Clock = 1'b0;
    logic               Reset = 1'b1;
    logic signed [15:0] LoadValue = '0;
    logic               LoadEnable = 1'b0;
    logic signed [8:0]  Offset = '0;
    logic               OffsetEnable = 1'b0;
    logic signed [15:0] CounterValue;
`ifdef PC_WRAP_FLAG_EN
    logic               Wrapped;
`endif

    int errors = 0;
    int checks = 0;

    // literal expectation for the value after the coming edge
    bit          lit_en   = 1'b0;
    logic [15:0] lit_val  = '0;
    bit          lit_wrap = 1'b0;

    program_counter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .LoadValue    (LoadValue),
        .LoadEnable   (LoadEnable),
        .Offset       (Offset),
        .OffsetEnable (OffsetEnable),
`ifdef PC_WRAP_FLAG_EN
        .Wrapped      (Wrapped),
`endif
        .CounterValue (CounterValue)
    );

    always #5 Clock = ~Clock;

    // Behavioural model and the single compare process.
    bit          model_valid = 1'b0;
    logic [15:0] model_pc    = '0;
    bit          model_wrap  = 1'b0;

    always @(posedge Clock) begin
        int          s;
        bit          p_en;
        logic [15:0] p_val;
        bit          p_wrap;
        if (Reset) begin
            model_valid = 1'b1;
            model_pc    = 16'h0000;
            model_wrap  = 1'b0;
        end else if (LoadEnable) begin
            model_pc   = LoadValue;
            model_wrap = 1'b0;
        end else if (OffsetEnable) begin
            s          = int'(model_pc) + int'(Offset);
            model_wrap = (s < 0) || (s > 65535);
            model_pc   = 16'(s & 32'hFFFF);
        end else begin
            s          = int'(model_pc) + 1;
            model_wrap = (s > 65535);
            model_pc   = 16'(s & 32'hFFFF);
        end
        p_en   = lit_en;
        p_val  = lit_val;
        p_wrap = lit_wrap;
        @(negedge Clock);
        if (model_valid) begin
            checks++;
            if (CounterValue !== model_pc) begin
                errors++;
                $display("FAIL model_pc t=%0t got=%h exp=%h", $time, CounterValue, model_pc);
            end
`ifdef PC_WRAP_FLAG_EN
            checks++;
            if (Wrapped !== model_wrap) begin
                errors++;
                $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, Wrapped, model_wrap);
            end
`endif
        end
        if (p_en) begin
            checks++;
            if (CounterValue !== p_val) begin
                errors++;
                $display("FAIL literal_pc t=%0t got=%h exp=%h", $time, CounterValue, p_val);
            end
`ifdef PC_WRAP_FLAG_EN
            checks++;
            if (Wrapped !== p_wrap) begin
                errors++;
                $display("FAIL literal_wrap t=%0t got=%b exp=%b", $time, Wrapped, p_wrap);
            end
`endif
        end
    end

    task automatic drive(input logic r, input logic le, input logic [15:0] lv,
                         input logic oe, input logic signed [8:0] off,
                         input bit le_lit, input logic [15:0] v_lit, input bit w_lit);
        @(negedge Clock);
        Reset        = r;
        LoadEnable   = le;
        LoadValue    = lv;
        OffsetEnable = oe;
        Offset       = off;
        lit_en       = le_lit;
        lit_val      = v_lit;
        lit_wrap     = w_lit;
    endtask

    initial begin
        logic [15:0] lv;
        // reset then 9 idle cycles counts to 9
        drive(1, 0, 16'h0, 0, 9'sd0, 1, 16'h0000, 0);
        for (int i = 1; i <= 9; i++) drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'(i), 0);
        // jump then increment
        drive(0, 1, 16'hF0F0, 0, 9'sd0, 1, 16'hF0F0, 0);
        drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'hF0F1, 0);
        // reset beats load and offset
        drive(1, 1, 16'h1234, 1, 9'sd7, 1, 16'h0000, 0);
        drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'h0001, 0);
        // relative branches, including borrow below zero
        drive(0, 0, 16'h0, 1, 9'sd55, 1, 16'd56, 0);
        drive(0, 0, 16'h0, 1, -9'sd56, 1, 16'd0, 0);
        drive(0, 0, 16'h0, 1, -9'sd1, 1, 16'hFFFF, 1);
        // load beats offset
        drive(0, 1, 16'd100, 1, 9'sd5, 1, 16'd100, 0);
        // increment wraps past the top
        drive(0, 1, 16'hFFFF, 0, 9'sd0, 1, 16'hFFFF, 0);
        drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'h0000, 1);
        drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'h0001, 0);
        // signed overflow boundary is not a wrap
        drive(0, 1, 16'h7FFF, 0, 9'sd0, 1, 16'h7FFF, 0);
        drive(0, 0, 16'h0, 0, 9'sd0, 1, 16'h8000, 0);
        // largest positive offset carrying out
        drive(0, 1, 16'hFF80, 0, 9'sd0, 1, 16'hFF80, 0);
        drive(0, 0, 16'h0, 1, 9'sd255, 1, 16'h007F, 1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       lv = 16'hFFFF;
                1:       lv = 16'h7FFF;
                2:       lv = 16'h0000 + 16'($urandom_range(0, 3));
                default: lv = 16'($urandom);
            endcase
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  lv,
                  ($urandom_range(0, 2) == 0),
                  9'($urandom),
                  0, 16'h0, 0);
        end

        drive(0, 0, 16'h0, 0, 9'sd0, 0, 16'h0, 0);
        repeat (3) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
